regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write, two-read core register file.
- Adds configurable data width and register count, N read ports, two write ports with fixed priority, and asynchronous clear.
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight producers.
- Sits between decode (read and busy ports) and writeback (write ports) in the RV32 core.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports; legal range 1..4.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  2  write enable per write port; bit 1 is port 1.
- waddr  in  2*ADDR_W  write indices, packed, port 0 in the low slice.
- wdata  in  2*DATA_W  write data, packed, port 0 in the low slice.
- raddr  in  NUM_RD*ADDR_W  read indices, packed.
- rdata  out  NUM_RD*DATA_W  read data, packed; combinational.
- rbusy  out  NUM_RD  busy bit of the register addressed by each read port; combinational.
- busy_set  in  1  marks register busy_addr as having a pending producer.
- busy_addr  in  ADDR_W  index to mark busy.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers clear to 0 and all busy bits clear.
  - rdata therefore reads 0 and rbusy/busy_any read 0 while reset is held.
  - Reset asserted mid-write discards the write.
  - Reset deasserts synchronously to clk at the block level; no state changes on the releasing edge other than normal writes.
- Register 0:
  - reads return 0 and its rbusy is 0.
  - writes to it are ignored and busy_set on it is ignored.
  - No storage is implemented for index 0.
- Write:
  - On a rising edge, for each port with we[i]=1 and waddr[i]!=0, mem[waddr[i]] <= wdata[i].
  - Latency 1 cycle: the value is visible to reads from the cycle after the edge.
- Write collision: when both ports are enabled to the same nonzero index, port 1 wins and port 0's data is dropped. No error flag.
- Read:
  - rdata[k] = mem[raddr[k]], fully combinational and independent per port.
  - Any number of read ports may address the same register.
- Busy scoreboard:
  - One bit per register, cleared on any write (either port) to that index.
  - busy_set on an edge sets bit busy_addr.
  - Simultaneous set and clear of the same index in the same cycle: set wins, because a new producer has issued.
  - busy_set to an already-busy register keeps it set.
  - rbusy[k] = busy[raddr[k]], evaluated combinationally before the edge.
- Out-of-range parameters (NUM_RD outside 1..4) are stopped with an elaboration-time error.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding is active. If any we[i]=1 with waddr[i]==raddr[k]!=0 in the current cycle, rdata[k] = wdata[i], with port 1 taking priority.
  - In the same case rbusy[k] reads 0, since the producer is completing this cycle.
- Not defined: rdata and rbusy reflect state only; a same-cycle write is seen one cycle later. Decode must stall one extra cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W constants;
  - a ZERO_REG index constant (0);
  - a typedef for the packed write-request bundle (we, addr, data).
- One natural sub-module, regfile_wr_arb: resolves the two write ports into a per-register write strobe and data select, including the port-1-wins rule and the index-0 mask. The decoded strobe is reused for busy clear and for bypass.

Test Plan:
- Reset then read: hold rst_n=0 for 2 cycles with arbitrary inputs, read raddr=3 and 31 -> rdata=0, rbusy=0, busy_any=0.
- Single write: we=01, waddr0=3, wdata0=8, then raddr0=3 next cycle -> rdata0=8. Write x0 with 0xDEADBEEF -> read x0 returns 0.
- Collision: both ports write x2 (port 0 data=5, port 1 data=9) -> x2 reads 9 next cycle.
- Scoreboard:
  - busy_set x7 -> rbusy=1 and busy_any=1 from the next cycle.
  - Writeback to x7 -> busy clears the next cycle.
  - Same-cycle busy_set x7 plus write x7 -> x7 stays busy with the new data stored.
- Bypass:
  - With REGFILE_BYPASS_EN, write x4=0x55 while raddr1=4 -> rdata1=0x55 in the same cycle.
  - Without the macro -> old value in that cycle, 0x55 in the next.
- Mid-operation reset: pulse rst_n low between edges while x5 holds 0x1234 and is busy -> x5 reads 0 and is not busy immediately, with no clock edge needed.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the multi-port register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - decodes two write ports into per-register strobes
// o_sel_p1 marks registers whose data comes from port 1; it also settles same-index collisions.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [1:0]          i_we,
  input  logic [2*ADDR_W-1:0] i_waddr,
  output logic [2**ADDR_W-1:0] o_strobe,
  output logic [2**ADDR_W-1:0] o_sel_p1
);
  localparam int DEPTH = 2**ADDR_W;

  logic [ADDR_W-1:0] w_addr0;
  logic [ADDR_W-1:0] w_addr1;

  assign w_addr0 = i_waddr[ADDR_W-1:0];
  assign w_addr1 = i_waddr[2*ADDR_W-1:ADDR_W];

  for (genvar r = 0; r < DEPTH; r++) begin : g_dec
    if (r == ZERO_REG) begin : g_zero
      assign o_strobe[r] = 1'b0;
      assign o_sel_p1[r] = 1'b0;
    end else begin : g_reg
      logic w_hit0;
      logic w_hit1;
      assign w_hit0      = i_we[0] && (w_addr0 == ADDR_W'(r));
      assign w_hit1      = i_we[1] && (w_addr1 == ADDR_W'(r));
      assign o_strobe[r] = w_hit0 | w_hit1;
      assign o_sel_p1[r] = w_hit1;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               we,
  input  logic [2*ADDR_W-1:0]      waddr,
  input  logic [2*DATA_W-1:0]      wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  output logic                     busy_any
);
  localparam int DEPTH = 2**ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be in 1..4");
  end

  logic [DEPTH-1:1][DATA_W-1:0] r_mem;
  logic [DEPTH-1:1]             r_busy;
  logic [DEPTH-1:0][DATA_W-1:0] w_mem_view;
  logic [DEPTH-1:0]             w_busy_view;
  logic [DEPTH-1:0]             w_strobe;
  logic [DEPTH-1:0]             w_sel_p1;
  logic [DATA_W-1:0]            w_wd0;
  logic [DATA_W-1:0]            w_wd1;

  assign w_wd0 = wdata[DATA_W-1:0];
  assign w_wd1 = wdata[2*DATA_W-1:DATA_W];

  regfile_wr_arb #(.ADDR_W(ADDR_W)) u_wr_arb (
    .i_we     (we),
    .i_waddr  (waddr),
    .o_strobe (w_strobe),
    .o_sel_p1 (w_sel_p1)
  );

  // A busy_set in the same cycle as a writeback wins: a new producer has issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem  <= '0;
      r_busy <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (w_strobe[r]) begin
          r_mem[r] <= w_sel_p1[r] ? w_wd1 : w_wd0;
        end
        r_busy[r] <= (busy_set && (busy_addr == ADDR_W'(r))) || (r_busy[r] && !w_strobe[r]);
      end
    end
  end

  assign w_mem_view  = {r_mem, {DATA_W{1'b0}}};
  assign w_busy_view = {r_busy, 1'b0};
  assign busy_any    = |r_busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = raddr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign rdata[k*DATA_W +: DATA_W] = w_strobe[w_ra] ? (w_sel_p1[w_ra] ? w_wd1 : w_wd0)
                                                      : w_mem_view[w_ra];
    assign rbusy[k] = w_busy_view[w_ra] && !w_strobe[w_ra];
`else
    assign rdata[k*DATA_W +: DATA_W] = w_mem_view[w_ra];
    assign rbusy[k] = w_busy_view[w_ra];
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk;
  logic                     rst_n;
  logic [1:0]               we;
  logic [2*ADDR_W-1:0]      waddr;
  logic [2*DATA_W-1:0]      wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     busy_set;
  logic [ADDR_W-1:0]        busy_addr;
  logic                     busy_any;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .busy_any  (busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we       = 2'b00;
    busy_set = 1'b0;
  endtask

  task automatic set_wr(input logic [1:0] en, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                        input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    we    = en;
    waddr = {a1, a0};
    wdata = {d1, d0};
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    set_wr(2'b11, 5'd3, 32'hAAAA_0003, 5'd31, 32'hBBBB_001F);
    busy_set  = 1'b1;
    busy_addr = 5'd3;
    raddr     = {5'd31, 5'd3};
    step();
    step();
    checks++;
    if (rdata !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 64'h0);
    end
    checks++;
    if (rbusy !== 2'b00) begin
      errors++; $display("FAIL reset_rbusy: got %b expected %b", rbusy, 2'b00);
    end
    checks++;
    if (busy_any !== 1'b0) begin
      errors++; $display("FAIL reset_busy_any: got %b expected %b", busy_any, 1'b0);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    set_wr(2'b01, 5'd3, 32'd8, 5'd0, 32'd0);
    step();
    idle();
    raddr = {5'd0, 5'd3};
    #1;
    checks++;
    if (rdata[31:0] !== 32'd8) begin
      errors++; $display("FAIL write_x3: got %h expected %h", rdata[31:0], 32'd8);
    end
    set_wr(2'b01, 5'd0, 32'hDEAD_BEEF, 5'd0, 32'd0);
    busy_set  = 1'b1;
    busy_addr = 5'd0;
    step();
    idle();
    raddr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rdata[31:0] !== 32'd0) begin
      errors++; $display("FAIL write_x0: got %h expected %h", rdata[31:0], 32'd0);
    end
    checks++;
    if (rbusy !== 2'b00 || busy_any !== 1'b0) begin
      errors++; $display("FAIL busy_x0: got rbusy=%b any=%b expected rbusy=00 any=0", rbusy, busy_any);
    end
  endtask

  task automatic test_collision();
    set_wr(2'b11, 5'd2, 32'd5, 5'd2, 32'd9);
    step();
    idle();
    raddr = {5'd2, 5'd2};
    #1;
    checks++;
    if (rdata[31:0] !== 32'd9) begin
      errors++; $display("FAIL collision_rd0: got %h expected %h", rdata[31:0], 32'd9);
    end
    checks++;
    if (rdata[63:32] !== 32'd9) begin
      errors++; $display("FAIL collision_rd1: got %h expected %h", rdata[63:32], 32'd9);
    end
  endtask

  task automatic test_scoreboard();
    busy_set  = 1'b1;
    busy_addr = 5'd7;
    raddr     = {5'd3, 5'd7};
    #1;
    checks++;
    if (rbusy[0] !== 1'b0) begin
      errors++; $display("FAIL busy_before_edge: got %b expected %b", rbusy[0], 1'b0);
    end
    step();
    idle();
    #1;
    checks++;
    if (rbusy !== 2'b01 || busy_any !== 1'b1) begin
      errors++; $display("FAIL busy_set_x7: got rbusy=%b any=%b expected rbusy=01 any=1", rbusy, busy_any);
    end
    set_wr(2'b01, 5'd7, 32'h77, 5'd0, 32'd0);
    step();
    idle();
    #1;
    checks++;
    if (rbusy[0] !== 1'b0 || busy_any !== 1'b0) begin
      errors++; $display("FAIL busy_clear_x7: got rbusy=%b any=%b expected rbusy=0 any=0", rbusy[0], busy_any);
    end
    checks++;
    if (rdata[31:0] !== 32'h77) begin
      errors++; $display("FAIL wb_data_x7: got %h expected %h", rdata[31:0], 32'h77);
    end
    set_wr(2'b10, 5'd0, 32'd0, 5'd7, 32'hAA);
    busy_set  = 1'b1;
    busy_addr = 5'd7;
    step();
    idle();
    #1;
    checks++;
    if (rbusy[0] !== 1'b1 || busy_any !== 1'b1) begin
      errors++; $display("FAIL set_wins_x7: got rbusy=%b any=%b expected rbusy=1 any=1", rbusy[0], busy_any);
    end
    checks++;
    if (rdata[31:0] !== 32'hAA) begin
      errors++; $display("FAIL set_wins_data: got %h expected %h", rdata[31:0], 32'hAA);
    end
    set_wr(2'b01, 5'd7, 32'hAB, 5'd0, 32'd0);
    step();
    idle();
    #1;
    checks++;
    if (busy_any !== 1'b0) begin
      errors++; $display("FAIL busy_final_clear: got %b expected %b", busy_any, 1'b0);
    end
  endtask

  task automatic test_bypass();
    set_wr(2'b01, 5'd4, 32'h11, 5'd0, 32'd0);
    busy_set  = 1'b1;
    busy_addr = 5'd4;
    step();
    idle();
    set_wr(2'b11, 5'd4, 32'h33, 5'd4, 32'h55);
    raddr = {5'd4, 5'd3};
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (rdata[63:32] !== 32'h55) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rdata[63:32], 32'h55);
    end
    checks++;
    if (rbusy[1] !== 1'b0) begin
      errors++; $display("FAIL bypass_rbusy: got %b expected %b", rbusy[1], 1'b0);
    end
`else
    checks++;
    if (rdata[63:32] !== 32'h11) begin
      errors++; $display("FAIL nobypass_same_cycle: got %h expected %h", rdata[63:32], 32'h11);
    end
    checks++;
    if (rbusy[1] !== 1'b1) begin
      errors++; $display("FAIL nobypass_rbusy: got %b expected %b", rbusy[1], 1'b1);
    end
`endif
    checks++;
    if (rdata[31:0] !== 32'd8) begin
      errors++; $display("FAIL bypass_other_port: got %h expected %h", rdata[31:0], 32'd8);
    end
    step();
    idle();
    #1;
    checks++;
    if (rdata[63:32] !== 32'h55 || rbusy[1] !== 1'b0) begin
      errors++; $display("FAIL bypass_next_cycle: got %h/%b expected %h/0", rdata[63:32], rbusy[1], 32'h55);
    end
  endtask

  task automatic test_mid_reset();
    set_wr(2'b01, 5'd5, 32'h1234, 5'd0, 32'd0);
    busy_set  = 1'b1;
    busy_addr = 5'd5;
    step();
    idle();
    raddr = {5'd4, 5'd5};
    #1;
    checks++;
    if (rdata[31:0] !== 32'h1234 || rbusy[0] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_x5: got %h/%b expected %h/1", rdata[31:0], rbusy[0], 32'h1234);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdata !== 64'h0) begin
      errors++; $display("FAIL async_reset_rdata: got %h expected %h", rdata, 64'h0);
    end
    checks++;
    if (rbusy !== 2'b00 || busy_any !== 1'b0) begin
      errors++; $display("FAIL async_reset_busy: got rbusy=%b any=%b expected 00/0", rbusy, busy_any);
    end
    set_wr(2'b01, 5'd6, 32'h66, 5'd0, 32'd0);
    step();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    raddr = {5'd2, 5'd6};
    step();
    checks++;
    if (rdata !== 64'h0) begin
      errors++; $display("FAIL write_during_reset: got %h expected %h", rdata, 64'h0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    we        = '0;
    waddr     = '0;
    wdata     = '0;
    raddr     = '0;
    busy_set  = 1'b0;
    busy_addr = '0;
    test_reset();
    test_single_write();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
